sr_cmd_arbiter: RTL and testbench

SR_CMD_ARBITER -- requirements
Module: sr_cmd_arbiter

---
 rtl/sr_cmd_arbiter.sv | 117 +++++++++++
 tb/tb_sr_cmd_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_arbiter.sv
// rtl/sr_cmd_arbiter.sv - round-robin command arbiter driving one SR flip-flop
// Optional readback verify stage enabled by defining SR_CMD_ARBITER_VERIFY_EN.
module sr_cmd_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  input  logic             q_in,
  output logic             s,
  output logic             r,
  output logic [N_REQ-1:0] gnt,
  output logic             ack,
  output logic             err,
  output logic             busy
);

  localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

`ifdef SR_CMD_ARBITER_VERIFY_EN
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, ACK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE, ACK} state_t;
`endif

  state_t           state_q, state_d;
  logic [IW-1:0]    win_q;
  logic [IW-1:0]    rr_q;
  logic [IW-1:0]    pick;
  logic             found;
  logic             op_q;
  logic [N_REQ-1:0] gnt_q;
  logic [3:0]       cnt_q;
  int               idx;

  // Round-robin search: first requester at or after rr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  // Next-state logic; arbitration happens only in IDLE, commands always run to ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (found) state_d = DRIVE;
`ifdef SR_CMD_ARBITER_VERIFY_EN
      DRIVE:  if (cnt_q == 4'd0) state_d = SETTLE;
      SETTLE: state_d = ACK;
`else
      DRIVE:  if (cnt_q == 4'd0) state_d = ACK;
`endif
      ACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant latch, hold counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      op_q    <= 1'b0;
      gnt_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (found) begin
            win_q <= pick;
            op_q  <= op[pick];
            gnt_q <= N_REQ'(1) << pick;
            cnt_q <= 4'(HOLD_CYC - 1);
          end
        end
        DRIVE: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        ACK: begin
          gnt_q <= '0;
          rr_q  <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // s and r are decoded from a single state and one latched bit, so they are mutually exclusive.
  always_comb begin
    busy = (state_q != IDLE);
    s    = (state_q == DRIVE) &&  op_q;
    r    = (state_q == DRIVE) && !op_q;
    ack  = (state_q == ACK);
    gnt  = gnt_q;
  end

`ifdef SR_CMD_ARBITER_VERIFY_EN
  assign err = (state_q == ACK) && (q_in != op_q);
`else
  logic q_in_unused;
  assign q_in_unused = q_in;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// tb/tb_sr_cmd_arbiter.sv - self-checking bench for sr_cmd_arbiter
module tb_sr_cmd_arbiter;

`ifdef SR_CMD_ARBITER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int LAT = VER ? 3 : 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, force0, q_in, s, r, ack, err, busy;
  logic       q = 1'b0;
  logic [3:0] req, op, gnt;

  logic       rst3, q3_in, s3, r3, ack3, err3, busy3;
  logic       q3 = 1'b0;
  logic [3:0] req3, op3, gnt3;

  sr_cmd_arbiter #(.N_REQ(4), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .q_in(q_in),
    .s(s), .r(r), .gnt(gnt), .ack(ack), .err(err), .busy(busy)
  );

  sr_cmd_arbiter #(.N_REQ(4), .HOLD_CYC(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .op(op3), .q_in(q3_in),
    .s(s3), .r(r3), .gnt(gnt3), .ack(ack3), .err(err3), .busy(busy3)
  );

  // SR flip-flop models
  assign q_in  = force0 ? 1'b0 : q;
  assign q3_in = q3;
  always @(posedge clk) begin
    if (s) q <= 1'b1; else if (r) q <= 1'b0;
    if (s3) q3 <= 1'b1; else if (r3) q3 <= 1'b0;
  end

  typedef struct {
    logic [3:0] gnt;
    logic       err;
    logic       q;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] op;
    logic       f0;
    logic [3:0] gnt;
    logic       eop;
  } vec_t;

  exp_t sbq[$];
  exp_t e;
  vec_t vecs[7];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Invariants every cycle plus scoreboard compare on each ack
  always @(negedge clk) begin
    check("no_s_and_r", {31'd0, s && r}, 0);
    check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 1);
    check("no_s_and_r_h3", {31'd0, s3 && r3}, 0);
    check("gnt_onehot0_h3", {31'd0, $onehot0(gnt3)}, 1);
    if (ack) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=1 gnt=%0h expected no ack", gnt);
      end else begin
        e = sbq.pop_front();
        check("ack_gnt", {28'd0, gnt}, {28'd0, e.gnt});
        check("ack_err", {31'd0, err}, {31'd0, e.err});
        check("ack_q", {31'd0, q}, {31'd0, e.q});
      end
    end
  end

  task automatic wait_ack(output int n, output int sc, output int rc);
    n = 0; sc = 0; rc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (s) sc++;
      if (r) rc++;
      if (ack) return;
    end
    total++;
    bad++;
    $display("FAIL ack_timeout: got no ack in 20 cycles expected ack");
  endtask

  int n, sc, rc, ackn, last_r;
  logic [3:0] g_at_ack;

  initial begin
    // requester order from rr_ptr=0: 0 ->1, wrap to 0 ->1, 1 ->2, 2 ->3, 3 ->0, 2 ->3, 3 ->0
    vecs[0] = '{req: 4'b0001, op: 4'b0001, f0: 1'b0, gnt: 4'b0001, eop: 1'b1};
    vecs[1] = '{req: 4'b0001, op: 4'b0000, f0: 1'b0, gnt: 4'b0001, eop: 1'b0};
    vecs[2] = '{req: 4'b0110, op: 4'b0100, f0: 1'b0, gnt: 4'b0010, eop: 1'b0};
    vecs[3] = '{req: 4'b0110, op: 4'b0100, f0: 1'b0, gnt: 4'b0100, eop: 1'b1};
    vecs[4] = '{req: 4'b1001, op: 4'b0000, f0: 1'b0, gnt: 4'b1000, eop: 1'b0};
    vecs[5] = '{req: 4'b0100, op: 4'b0100, f0: 1'b1, gnt: 4'b0100, eop: 1'b1};
    vecs[6] = '{req: 4'b1111, op: 4'b1010, f0: 1'b0, gnt: 4'b1000, eop: 1'b1};

    rst = 1'b1; force0 = 1'b0; req = '0; op = '0;
    rst3 = 1'b1; req3 = '0; op3 = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", {28'd0, gnt}, 0);
    check("rst_sr", {30'd0, s, r}, 0);
    check("rst_ack_err_busy", {29'd0, ack, err, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0; rst3 = 1'b0;

    // table-driven single commands
    for (int i = 0; i < 7; i++) begin
      sbq.push_back('{gnt: vecs[i].gnt, err: vecs[i].f0 & VER, q: vecs[i].eop});
      req = vecs[i].req; op = vecs[i].op; force0 = vecs[i].f0;
      wait_ack(n, sc, rc);
      check($sformatf("v%0d_latency", i), n, LAT + 1);
      check($sformatf("v%0d_s_cycles", i), sc, {31'd0, vecs[i].eop});
      check($sformatf("v%0d_r_cycles", i), rc, {31'd0, !vecs[i].eop});
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_after_ack", i), {31'd0, busy}, 0);
    end
    req = '0; force0 = 1'b0;

    // contention: all requesting, order 0,1,2,3,0
    for (int i = 0; i < 5; i++)
      sbq.push_back('{gnt: 4'b0001 << (i % 4), err: 1'b0, q: ((i % 2) == 0)});
    req = 4'b1111; op = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      wait_ack(n, sc, rc);
      check($sformatf("cont%0d_latency", i), n, LAT + 1);
    end
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);

    // HOLD_CYC=3 reset op
    @(posedge clk); #1;
    req3 = 4'b0001; op3 = 4'b0000;
    ackn = 0; last_r = 0; sc = 0; rc = 0; n = 0; g_at_ack = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (s3) sc++;
      if (r3) begin rc++; last_r = n; end
      if (ack3) begin ackn = n; g_at_ack = gnt3; break; end
    end
    check("h3_ack_seen", {31'd0, ackn != 0}, 1);
    check("h3_r_cycles", rc, 3);
    check("h3_s_cycles", sc, 0);
    check("h3_ack_after_r", ackn - last_r, VER ? 2 : 1);
    check("h3_gnt", {28'd0, g_at_ack}, 4'b0001);
    check("h3_err", {31'd0, err3}, 0);
    @(posedge clk); #1;
    req3 = '0;

    // reset during the 2nd DRIVE cycle (rr_ptr now 1, so requester 2 wins)
    @(posedge clk); #1;
    req3 = 4'b0100; op3 = 4'b0100;
    repeat (3) @(negedge clk);
    check("h3_drive2_s", {28'd0, gnt3, s3}, {28'd0, 4'b0100, 1'b1});
    rst3 = 1'b1; req3 = '0;
    @(negedge clk);
    check("h3_rst_sr", {30'd0, s3, r3}, 0);
    check("h3_rst_gnt", {28'd0, gnt3}, 0);
    check("h3_rst_busy_ack", {30'd0, busy3, ack3}, 0);
    rst3 = 1'b0; req3 = 4'b1111; op3 = 4'b1111;
    ackn = 0; g_at_ack = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack3) begin ackn = 1; g_at_ack = gnt3; break; end
    end
    check("h3_post_rst_ack", ackn, 1);
    check("h3_post_rst_first_gnt", {28'd0, g_at_ack}, 4'b0001);
    @(posedge clk); #1;
    req3 = '0;

    // random stress on invariants
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      req3 = 4'($urandom);
      op3  = 4'($urandom);
      rst3 = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
